// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM with per-byte write enables behind the aligner's memory port.
// Latency: a write lands on its request edge; read data and readValid appear RD_LAT edges after the read request.
// Backpressure: o_busy is high while a read is still counting down. Requests sampled then are dropped and flag o_err.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_rden, i_wren      read / write request (write wins if both are high)
//   i_address           word address; addresses >= DEPTH read as zero and drop writes
//   i_byteena           byte-lane write enables, bit i -> i_writeData[8i+7:8i]
//   i_writeData         write data
//   o_readData          last completed read word, held between reads
//   o_readValid         one-cycle strobe when o_readData is updated
//   o_busy              read in flight, new requests are not accepted
//   o_err               sticky protocol-error flag, cleared only by reset
module data_mem_responder #(
  parameter int V      = 256,
  parameter int AW     = 14,
  parameter int DEPTH  = 16384,
  parameter int RD_LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_rden,
  input  logic            i_wren,
  input  logic [AW-1:0]   i_address,
  input  logic [V/8-1:0]  i_byteena,
  input  logic [V-1:0]    i_writeData,
  output logic [V-1:0]    o_readData,
  output logic            o_readValid,
  output logic            o_busy,
  output logic            o_err
);

  localparam int          NB       = V / 8;
  localparam int          IW       = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [1:0]  CNT_LOAD = 2'(RD_LAT - 1);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  // r_pend marks the last cycle of a read: the FSM is already back in IDLE and
  // the array is sampled on the coming edge. Dropping o_busy one cycle early lets
  // the aligner line up its next request for the very edge the data returns.
  logic          r_pend, w_pend_nxt;
  logic [V-1:0]  r_rdata;
  logic          r_rvld;
  logic          r_err;
  logic          w_wr_acc;
  logic          w_err_set;
  logic          w_wr_ok;
  logic [V-1:0]  w_rd_word;

  logic [V-1:0]  r_mem [DEPTH];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_pend_nxt  = 1'b0;
    w_wr_acc    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_wren) begin
          // Simultaneous read+write degrades to a plain write.
          w_wr_acc  = 1'b1;
          w_err_set = i_rden;
        end else if (i_rden) begin
          w_addr_nxt = i_address;
          w_cnt_nxt  = CNT_LOAD;
          if (RD_LAT == 1) w_pend_nxt  = 1'b1;
          else             w_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_err_set = i_rden | i_wren;
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) begin
          w_state_nxt = IDLE;
          w_pend_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_wr_ok   = w_wr_acc && ({1'b0, i_address} < DEPTH_W);
  // Array is read at the completion edge, so a write on that same edge is ordered after the read.
  assign w_rd_word = ({1'b0, r_addr} < DEPTH_W) ? r_mem[r_addr[IW-1:0]] : '0;

  // Memory has no reset: contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (i_byteena[i]) r_mem[i_address[IW-1:0]][8*i +: 8] <= i_writeData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_pend  <= 1'b0;
      r_rdata <= '0;
      r_rvld  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_pend  <= w_pend_nxt;
      r_rvld  <= r_pend;
      if (r_pend)    r_rdata <= w_rd_word;
      if (w_err_set) r_err   <= 1'b1;
    end
  end

  assign o_readData  = r_rdata;
  assign o_readValid = r_rvld;
  assign o_busy      = (r_state == RD_WAIT);
  assign o_err       = r_err;

endmodule
